ws2812_stream: RTL and testbench
================================

WS2812_STREAM -- requirements
Module: ws2812_stream

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 8, LEDs per frame (1..65535).
REQ-002 SHALL have parameter BITS_PER_LED, default 24, bits per LED (24 = RGB, 32 = RGBW).
REQ-003 SHALL have parameter CLK_PER_BIT, default 6, clocks per bit cell (>=4).
REQ-004 SHALL have parameter T0H, default 2, high clocks for a '0' bit (1 <= T0H < T1H).
REQ-005 SHALL have parameter T1H, default 4, high clocks for a '1' bit (T1H < CLK_PER_BIT).
REQ-006 SHALL have parameter RESET_CLKS, default 3000, low clocks of the latch gap (>=1).
REQ-007 SHALL have parameter AUTO_REPEAT, default 0; 1 = restart the frame after each latch gap without start.
REQ-008 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-009 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-010 SHALL have port start  input  1  frame request, sampled only in IDLE.
REQ-011 SHALL have port pix_data  input  BITS_PER_LED  pixel word, MSB transmitted first.
REQ-012 SHALL have port pix_valid  input  1  pix_data valid.
REQ-013 SHALL have port pix_ready  output  1  block can accept a pixel this cycle.
REQ-014 SHALL have port pix_num  output  16  index of the pixel currently requested (0..NUM_LEDS-1).
REQ-015 SHALL have port data  output  1  registered serial line to the LED tape.
REQ-016 SHALL have port busy  output  1  high from frame acceptance until the end of the latch gap.
REQ-017 SHALL have port frame_done  output  1  one-cycle pulse at the end of the latch gap.
REQ-018 SHALL have port underrun  output  1  one-cycle pulse when a pixel was substituted with zeros.

Function
REQ-019 SHALL implement states IDLE, PRIME, SEND, LATCH.
REQ-020 IDLE: data=0, busy=0, pix_ready=0; start=1 -> PRIME next cycle, busy=1, pix_num=0.
REQ-021 PRIME: pix_ready=1; line held low; waits indefinitely; transfer (pix_valid & pix_ready) loads the shift register -> SEND; first bit cell rises on data the cycle after the transfer.
REQ-022 SEND: each bit cell lasts exactly CLK_PER_BIT clocks; data=1 for the first T1H (bit=1) or T0H (bit=0) clocks, then 0.
REQ-023 Bits SHALL be transmitted MSB first, BITS_PER_LED cells per pixel, back to back with no gap between pixels.
REQ-024 A one-entry prefetch buffer SHALL exist; in SEND, pix_ready=1 while the buffer is empty and pixels remain unrequested; pix_num increments after each transfer.
REQ-025 At the end of a pixel's last bit cell, if pixels remain: load the buffer if full, else load all zeros, pulse underrun, and advance pix_num for the skipped pixel.
REQ-026 After the last pixel's last bit cell -> LATCH; data=0 for exactly RESET_CLKS clocks; pix_ready=0.
REQ-027 At the end of LATCH: frame_done pulses 1 cycle; next state is PRIME if AUTO_REPEAT=1, else IDLE with busy=0 in the same cycle as frame_done.
REQ-028 start SHALL be ignored outside IDLE.
REQ-029 pix_data sampled only on a transfer cycle; pix_valid without pix_ready has no effect.
REQ-030 Frame length in SEND SHALL be NUM_LEDS*BITS_PER_LED*CLK_PER_BIT clocks regardless of underruns.
REQ-031 Counters SHALL be sized by $clog2 of their maximum; no counter wraps except by the explicit reloads above.

Reset
REQ-032 rst=1 at any time, including mid-frame, SHALL force on the next edge: IDLE, data=0, busy=0, pix_ready=0, frame_done=0, underrun=0, pix_num=0, buffer empty.
REQ-033 start asserted together with rst SHALL be ignored.

Verification (NUM_LEDS=2, BITS_PER_LED=24, CLK_PER_BIT=6, T0H=2, T1H=4, RESET_CLKS=20 unless stated)
REQ-034 Reset: rst 3 cycles, pix_valid=1 -> all outputs 0, pix_ready stays 0 until start.
REQ-035 Frame 0x800001, 0x000000 always valid -> cell 1: 4 high/2 low; cells 2-23: 2/4; cell 24: 4/2; cells 25-48: 2/4; 288 clocks then 20 low; frame_done 1 cycle; busy falls in that cycle; underrun never.
REQ-036 Underrun: pix_valid dropped after first transfer -> pixel 1 sent as 24 zero cells, underrun pulses exactly once at the cell-24/25 boundary, frame still 288 clocks.
REQ-037 start pulsed mid-SEND and during LATCH -> no effect; AUTO_REPEAT=1 -> PRIME entered the cycle after frame_done, pix_num=0, no start needed.
REQ-038 rst asserted at clock 100 of SEND -> data=0 and busy=0 next edge; a following start yields a clean 288-clock frame.
REQ-039 BITS_PER_LED=32, NUM_LEDS=1, pixel 0xFFFFFFFF -> 32 cells of 4 high/2 low, 192 clocks then latch.

Source files
------------

// File: rtl/ws2812_stream.sv
// WS2812 serial frame generator.
// Pixels arrive through a valid/ready handshake with a one-entry prefetch buffer.
// Each bit is encoded as a high/low cell on a registered serial line, and every
// frame ends with a low latch gap. A missing pixel is sent as zeros so that
// the frame timing never changes.
module ws2812_stream #(
    parameter int NUM_LEDS     = 8,
    parameter int BITS_PER_LED = 24,
    parameter int CLK_PER_BIT  = 6,
    parameter int T0H          = 2,
    parameter int T1H          = 4,
    parameter int RESET_CLKS   = 3000,
    parameter int AUTO_REPEAT  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [BITS_PER_LED-1:0] pix_data,
    input  logic                    pix_valid,
    output logic                    pix_ready,
    output logic [15:0]             pix_num,
    output logic                    data,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    underrun
);

    localparam int CW = (CLK_PER_BIT  > 1) ? $clog2(CLK_PER_BIT)  : 1;
    localparam int BW = (BITS_PER_LED > 1) ? $clog2(BITS_PER_LED) : 1;
    localparam int PW = (NUM_LEDS     > 1) ? $clog2(NUM_LEDS)     : 1;
    localparam int LW = (RESET_CLKS   > 1) ? $clog2(RESET_CLKS)   : 1;

    localparam logic [CW-1:0] CELL_LAST  = CW'(CLK_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(BITS_PER_LED - 1);
    localparam logic [PW-1:0] PIX_LAST   = PW'(NUM_LEDS - 1);
    localparam logic [LW-1:0] LATCH_LAST = LW'(RESET_CLKS - 1);
    localparam logic [15:0]   NUM_LEDS_W = 16'(NUM_LEDS);
    localparam logic [CW-1:0] T0H_W      = CW'(T0H);
    localparam logic [CW-1:0] T1H_W      = CW'(T1H);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_SEND  = 2'd2,
        S_LATCH = 2'd3
    } state_t;

    state_t                  state, state_next;
    logic [BITS_PER_LED-1:0] shift_reg, buf_data;
    logic                    buf_full;
    logic [CW-1:0]           cell_cnt;
    logic [BW-1:0]           bit_cnt;
    logic [PW-1:0]           pix_cnt;
    logic [LW-1:0]           latch_cnt;
    logic                    data_d, busy_d, frame_done_d, underrun_d;

    logic          xfer, cell_end, pixel_end, last_pix, latch_end, underrun_evt;
    logic [CW-1:0] cell_inc, hi_len;

    assign pix_ready    = (state == S_PRIME) ||
                          ((state == S_SEND) && !buf_full && (pix_num < NUM_LEDS_W));
    assign xfer         = pix_valid && pix_ready;
    assign cell_end     = (cell_cnt == CELL_LAST);
    assign pixel_end    = cell_end && (bit_cnt == BIT_LAST);
    assign last_pix     = (pix_cnt == PIX_LAST);
    assign latch_end    = (latch_cnt == LATCH_LAST);
    assign cell_inc     = cell_cnt + CW'(1);
    assign hi_len       = shift_reg[BITS_PER_LED-1] ? T1H_W : T0H_W;
    // A pixel boundary with nothing buffered and nothing arriving: send zeros.
    assign underrun_evt = (state == S_SEND) && pixel_end && !last_pix && !buf_full && !xfer;

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            data       <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_next;
            data       <= data_d;
            busy       <= busy_d;
            frame_done <= frame_done_d;
            underrun   <= underrun_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_PRIME; else state_next = S_IDLE;
            S_PRIME: if (xfer) state_next = S_SEND; else state_next = S_PRIME;
            S_SEND:  if (pixel_end && last_pix) state_next = S_LATCH; else state_next = S_SEND;
            S_LATCH: begin
                if (latch_end) state_next = (AUTO_REPEAT != 0) ? S_PRIME : S_IDLE;
                else           state_next = S_LATCH;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Output decode: values the output registers take on the coming edge.
    always_comb begin
        data_d       = 1'b0;
        busy_d       = (state_next != S_IDLE);
        frame_done_d = 1'b0;
        underrun_d   = 1'b0;
        case (state)
            S_PRIME: begin
                // The first cell of every bit starts high, because T0H >= 1.
                if (xfer) data_d = 1'b1; else data_d = 1'b0;
            end
            S_SEND: begin
                if (cell_end) data_d = !(pixel_end && last_pix);
                else          data_d = (cell_inc < hi_len);
                underrun_d = underrun_evt;
            end
            S_LATCH: frame_done_d = latch_end;
            default: data_d = 1'b0;
        endcase
    end

    // Datapath: shift register, prefetch buffer, cell/bit/pixel/latch counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
            buf_data  <= '0;
            buf_full  <= 1'b0;
            cell_cnt  <= '0;
            bit_cnt   <= '0;
            pix_cnt   <= '0;
            latch_cnt <= '0;
            pix_num   <= 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    pix_num  <= 16'd0;
                    buf_full <= 1'b0;
                end
                S_PRIME: begin
                    if (xfer) begin
                        shift_reg <= pix_data;
                        pix_num   <= pix_num + 16'd1;
                        cell_cnt  <= '0;
                        bit_cnt   <= '0;
                        pix_cnt   <= '0;
                    end
                end
                S_SEND: begin
                    if (xfer || underrun_evt) pix_num <= pix_num + 16'd1;
                    // An incoming pixel goes straight to the shifter when it lands on a pixel boundary.
                    if (xfer && !(pixel_end && !last_pix)) begin
                        buf_data <= pix_data;
                        buf_full <= 1'b1;
                    end
                    if (cell_end) begin
                        cell_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt   <= '0;
                            latch_cnt <= '0;
                            if (!last_pix) begin
                                pix_cnt <= pix_cnt + PW'(1);
                                if (buf_full) begin
                                    shift_reg <= buf_data;
                                    buf_full  <= 1'b0;
                                end else if (xfer) begin
                                    shift_reg <= pix_data;
                                end else begin
                                    shift_reg <= '0;
                                end
                            end
                        end else begin
                            bit_cnt   <= bit_cnt + BW'(1);
                            shift_reg <= shift_reg << 1;
                        end
                    end else begin
                        cell_cnt <= cell_inc;
                    end
                end
                S_LATCH: begin
                    if (latch_end) begin
                        latch_cnt <= '0;
                        pix_num   <= 16'd0;
                    end else begin
                        latch_cnt <= latch_cnt + LW'(1);
                    end
                end
                default: pix_num <= 16'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_stream.sv
// Self-checking bench for ws2812_stream: expected line levels are queued
// when pixels are driven and popped cycle by cycle as the DUT transmits.
module tb_ws2812_stream;

    localparam int RC = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, pix_valid;
    logic [23:0] pix_data;
    logic        pix_ready, data, busy, frame_done, underrun;
    logic [15:0] pix_num;

    logic        start2, pix_valid2;
    logic [31:0] pix_data2;
    logic        pix_ready2, data2, busy2, frame_done2, underrun2;
    logic [15:0] pix_num2;

    ws2812_stream #(.NUM_LEDS(2), .BITS_PER_LED(24), .CLK_PER_BIT(6), .T0H(2), .T1H(4),
                    .RESET_CLKS(RC), .AUTO_REPEAT(0)) u_dut (
        .clk(clk), .rst(rst), .start(start), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .pix_num(pix_num), .data(data), .busy(busy),
        .frame_done(frame_done), .underrun(underrun));

    ws2812_stream #(.NUM_LEDS(1), .BITS_PER_LED(32), .CLK_PER_BIT(6), .T0H(2), .T1H(4),
                    .RESET_CLKS(RC), .AUTO_REPEAT(1)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .pix_data(pix_data2), .pix_valid(pix_valid2),
        .pix_ready(pix_ready2), .pix_num(pix_num2), .data(data2), .busy(busy2),
        .frame_done(frame_done2), .underrun(underrun2));

    int   n_cmp = 0;
    int   n_bad = 0;
    logic exp_q[$];

    typedef struct {
        logic [23:0] p0;
        logic [23:0] p1;
        bit          v1;
        bit          poke;
        int          abort_at;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected line level per clock for one word, MSB first, 6-clock cells.
    task automatic push_word(input logic [31:0] w, input int nbits);
        for (int b = nbits - 1; b >= 0; b--) begin
            for (int c = 0; c < 6; c++) exp_q.push_back(c < (w[b] ? 4 : 2));
        end
    endtask

    task automatic push_latch();
        for (int k = 0; k < RC; k++) exp_q.push_back(1'b0);
    endtask

    task automatic run_frame(input vec_t v);
        int ur_seen;
        exp_q.delete();
        push_word({8'h00, v.p0}, 24);
        push_word(v.v1 ? {8'h00, v.p1} : 32'h0, 24);
        push_latch();
        @(negedge clk);
        pix_data = v.p0; pix_valid = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("prime_ready", {31'd0, pix_ready}, 32'd1);
        chk("prime_num", {16'd0, pix_num}, 32'd0);
        chk("prime_busy", {31'd0, busy}, 32'd1);
        chk("prime_data", {31'd0, data}, 32'd0);
        @(posedge clk);
        #1;
        pix_data = v.p1; pix_valid = v.v1;
        ur_seen = 0;
        for (int i = 0; i < 288 + RC; i++) begin
            @(negedge clk);
            chk($sformatf("data[%0d]", i), {31'd0, data}, {31'd0, exp_q.pop_front()});
            chk("busy_frame", {31'd0, busy}, 32'd1);
            chk("fd_frame", {31'd0, frame_done}, 32'd0);
            if (i == 0) chk("num_after_xfer", {16'd0, pix_num}, 32'd1);
            if (underrun) begin
                ur_seen++;
                chk("underrun_cycle", i, 32'd144);
            end
            if (i >= 288) chk("latch_ready", {31'd0, pix_ready}, 32'd0);
            if (v.poke && (i == 50 || i == 295)) start = 1'b1; else start = 1'b0;
            if (i == v.abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("abort_data", {31'd0, data}, 32'd0);
                chk("abort_busy", {31'd0, busy}, 32'd0);
                chk("abort_ready", {31'd0, pix_ready}, 32'd0);
                chk("abort_num", {16'd0, pix_num}, 32'd0);
                chk("abort_fd", {31'd0, frame_done}, 32'd0);
                exp_q.delete();
                pix_valid = 1'b0;
                return;
            end
        end
        @(negedge clk);
        chk("frame_done", {31'd0, frame_done}, 32'd1);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        chk("ready_at_done", {31'd0, pix_ready}, 32'd0);
        chk("underrun_count", ur_seen, v.v1 ? 32'd0 : 32'd1);
        @(negedge clk);
        chk("fd_one_cycle", {31'd0, frame_done}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_ready", {31'd0, pix_ready}, 32'd0);
        pix_valid = 1'b0;
    endtask

    // One 32-bit frame on the auto-repeat instance, entered from PRIME.
    task automatic run_frame32(input logic [31:0] w);
        exp_q.delete();
        push_word(w, 32);
        push_latch();
        pix_data2 = w; pix_valid2 = 1'b1;
        @(posedge clk);
        #1;
        pix_valid2 = 1'b0;
        for (int i = 0; i < 192 + RC; i++) begin
            @(negedge clk);
            chk($sformatf("data2[%0d]", i), {31'd0, data2}, {31'd0, exp_q.pop_front()});
            chk("busy2_frame", {31'd0, busy2}, 32'd1);
            chk("fd2_frame", {31'd0, frame_done2}, 32'd0);
            if (underrun2) chk("underrun2", 32'd1, 32'd0);
        end
        @(negedge clk);
        chk("fd2", {31'd0, frame_done2}, 32'd1);
        chk("repeat_busy", {31'd0, busy2}, 32'd1);
        chk("repeat_ready", {31'd0, pix_ready2}, 32'd1);
        chk("repeat_num", {16'd0, pix_num2}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{p0: 24'h800001, p1: 24'h000000, v1: 1'b1, poke: 1'b0, abort_at: -1};
        tbl[1] = '{p0: 24'hFFFFFF, p1: 24'hA5A5A5, v1: 1'b1, poke: 1'b1, abort_at: -1};
        tbl[2] = '{p0: 24'h123456, p1: 24'hDEADBE, v1: 1'b0, poke: 1'b0, abort_at: -1};
        tbl[3] = '{p0: 24'h5A5A5A, p1: 24'h00FF00, v1: 1'b1, poke: 1'b0, abort_at: 100};
        tbl[4] = '{p0: 24'h800001, p1: 24'h000000, v1: 1'b1, poke: 1'b0, abort_at: -1};

        rst = 1'b1; start = 1'b0; pix_valid = 1'b1; pix_data = 24'hFFFFFF;
        start2 = 1'b0; pix_valid2 = 1'b0; pix_data2 = 32'h0;

        // Reset held three cycles with pix_valid high.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_data", {31'd0, data}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_ready", {31'd0, pix_ready}, 32'd0);
            chk("rst_fd", {31'd0, frame_done}, 32'd0);
            chk("rst_ur", {31'd0, underrun}, 32'd0);
            chk("rst_num", {16'd0, pix_num}, 32'd0);
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("idle_ready_wait", {31'd0, pix_ready}, 32'd0);
            chk("idle_busy_wait", {31'd0, busy}, 32'd0);
        end

        // start together with rst is ignored.
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("start_in_rst_busy", {31'd0, busy}, 32'd0);
        chk("start_in_rst_ready", {31'd0, pix_ready}, 32'd0);
        pix_valid = 1'b0;

        for (int t = 0; t < 5; t++) run_frame(tbl[t]);

        // Auto-repeat instance: one started frame, then one with no start.
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        chk("prime2_ready", {31'd0, pix_ready2}, 32'd1);
        run_frame32(32'hFFFFFFFF);
        run_frame32(32'h00000000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
